// File: rtl/mic_pkg.sv
// Shared constants and types for the stereo PDM microphone capture path.
package mic_pkg;

  localparam int unsigned CIC_ORDER = 4;
  localparam int unsigned ACC_W     = 26;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned OUT_LSB   = 9;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] pcm_t;

  typedef struct packed {
    pcm_t l;
    pcm_t r;
  } pcm_pair_t;

  localparam acc_t ACC_PLUS  = ACC_W'(1);
  localparam acc_t ACC_MINUS = {ACC_W{1'b1}};
  localparam pcm_t PCM_MAX   = 16'sh7FFF;
  localparam pcm_t PCM_MIN   = 16'sh8000;
  // Comb results outside [SAT_LO, SAT_HI) do not fit after dropping OUT_LSB bits
  localparam acc_t SAT_HI    = ACC_W'(1) << (OUT_LSB + OUT_W - 1);
  localparam acc_t SAT_LO    = -SAT_HI;

  function automatic pcm_t sat_pcm(input acc_t x);
    if (x >= SAT_HI) begin
      return PCM_MAX;
    end else if (x < SAT_LO) begin
      return PCM_MIN;
    end else begin
      return OUT_W'(x >>> OUT_LSB);
    end
  endfunction

endpackage

// File: rtl/cic_decimator.sv
// One channel of 4th-order CIC decimation: integrators per bit, combs per dump strobe.
module cic_decimator
  import mic_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_vld_i,
  input  logic bit_i,
  input  logic dump_i,
  output pcm_t pcm_c_o
);

  acc_t integ_q [CIC_ORDER];
  acc_t integ_d [CIC_ORDER];
  acc_t dly_q   [CIC_ORDER];
  acc_t dly_d   [CIC_ORDER];

  // Integrator cascade; wrap-around is harmless since the combs undo it exactly
  always_comb begin
    acc_t sum;
    integ_d = integ_q;
    sum     = bit_i ? ACC_PLUS : ACC_MINUS;
    for (int i = 0; i < CIC_ORDER; i++) begin
      sum = integ_q[i] + sum;
      if (bit_vld_i) integ_d[i] = sum;
    end
  end

  // Comb cascade is combinational; delays only advance on the dump strobe
  always_comb begin
    acc_t stage;
    dly_d = dly_q;
    stage = integ_q[CIC_ORDER-1];
    for (int i = 0; i < CIC_ORDER; i++) begin
      if (dump_i) dly_d[i] = stage;
      stage = stage - dly_q[i];
    end
    pcm_c_o = sat_pcm(stage);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
    end else begin
      integ_q <= integ_d;
      dly_q   <= dly_d;
    end
  end

endmodule

// File: rtl/pdm_mic_capture.sv
// Stereo PDM microphone front end: bit clock, sampling, two CIC channels, output handshake.
module pdm_mic_capture
  import mic_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned DECIM   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    pdm_clk,
  input  logic                    pdm_data,
  output logic signed [OUT_W-1:0] sample_l,
  output logic signed [OUT_W-1:0] sample_r,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overflow
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned BIT_W = $clog2(DECIM);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pdm_clk_q, pdm_clk_d;
  logic [1:0]       sync_q, sync_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dec_stb_q, dec_stb_d;
  pcm_pair_t        pair_q, pair_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  logic left_vld_c, right_vld_c;
  pcm_t pcm_l_c, pcm_r_c;

  assign left_vld_c  = (div_cnt_q == DIV_W'(HALF - 1));
  assign right_vld_c = (div_cnt_q == DIV_W'(CLK_DIV - 1));

  cic_decimator u_cic_l (
    .clk       (clk),
    .rst       (rst),
    .bit_vld_i (left_vld_c),
    .bit_i     (sync_q[1]),
    .dump_i    (dec_stb_q),
    .pcm_c_o   (pcm_l_c)
  );

  cic_decimator u_cic_r (
    .clk       (clk),
    .rst       (rst),
    .bit_vld_i (right_vld_c),
    .bit_i     (sync_q[1]),
    .dump_i    (dec_stb_q),
    .pcm_c_o   (pcm_r_c)
  );

  always_comb begin
    div_cnt_d = right_vld_c ? '0 : div_cnt_q + DIV_W'(1);
    pdm_clk_d = (div_cnt_d < DIV_W'(HALF));
    sync_d    = {sync_q[0], pdm_data};
    bit_cnt_d = right_vld_c ? bit_cnt_q + BIT_W'(1) : bit_cnt_q;
    dec_stb_d = right_vld_c && (bit_cnt_q == BIT_W'(DECIM - 1));
    pair_d    = pair_q;
    valid_d   = valid_q;
    ovf_d     = ovf_q;

    if (valid_q && sample_ready) valid_d = 1'b0;
    // A new pair is accepted if the slot is free or being emptied this cycle
    if (dec_stb_q) begin
      if (!valid_q || sample_ready) begin
        pair_d.l = pcm_l_c;
        pair_d.r = pcm_r_c;
        valid_d  = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
      sync_q    <= '0;
      bit_cnt_q <= '0;
      dec_stb_q <= 1'b0;
      pair_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= pdm_clk_d;
      sync_q    <= sync_d;
      bit_cnt_q <= bit_cnt_d;
      dec_stb_q <= dec_stb_d;
      pair_q    <= pair_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pdm_clk      = pdm_clk_q;
  assign sample_l     = pair_q.l;
  assign sample_r     = pair_q.r;
  assign sample_valid = valid_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture; expected PCM values are hand-derived CIC step responses.
module tb_pdm_mic_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pdm_clk;
  logic        pdm_data;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overflow;

  // 0: line held low, 1: line held high, 2: high in left slot / low in right slot
  logic [1:0]  mode = 2'd1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;

  assign pdm_data = (mode == 2'd2) ? pdm_clk : mode[0];

  pdm_mic_capture #(.CLK_DIV(16), .DECIM(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .pdm_clk      (pdm_clk),
    .pdm_data     (pdm_data),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // cyc=1 denotes the first cycle in which the registers run out of reset
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_pair(input string tag);
    for (int i = 0; i < 1500 && !sample_valid; i++) step();
    check_eq({tag, "_arrival"}, 32'(sample_valid), 32'd1);
  endtask

  // Step response of a 4th-order, R=64 CIC from zero state, bits [25:9]:
  //   pair1 = C(67,4)=766480 -> 1497 (0x05D9), negative -> -1498 (0xFA26)
  //   pair2 = 8650720 -> 0x41FF, pair3 = 16141840 -> 0x7B27, pair4+ = 2^24 -> sat
  initial begin
    int t_rise;
    int hi;
    int changes;
    int hs;

    mode         = 2'd1;
    sample_ready = 1'b1;
    rst          = 1'b1;
    repeat (3) step();
    check_eq("rst_pdm_clk", 32'(pdm_clk), 32'd0);
    check_eq("rst_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_sample_l", 32'(sample_l), 32'd0);
    check_eq("rst_sample_r", 32'(sample_r), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    cyc = 1;

    // Constant high line, ready tied high
    check_eq("pdm_clk_c0", 32'(pdm_clk), 32'd0);
    step();
    check_eq("pdm_clk_rise", 32'(pdm_clk), 32'd1);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      hi += int'(pdm_clk);
      step();
    end
    check_eq("pdm_clk_duty", 32'(hi), 32'd8);

    wait_pair("ones_p1");
    t_rise = cyc;
    check_eq("ones_p1_latency", 32'(cyc), 32'd1026);
    check_eq("ones_p1_l", 32'(sample_l), 32'h05D9);
    check_eq("ones_p1_r", 32'(sample_r), 32'h05D9);
    step();
    check_eq("ones_valid_drop", 32'(sample_valid), 32'd0);
    wait_pair("ones_p2");
    check_eq("pair_period", 32'(cyc - t_rise), 32'd1024);
    check_eq("ones_p2_l", 32'(sample_l), 32'h41FF);
    step();
    wait_pair("ones_p3");
    check_eq("ones_p3_r", 32'(sample_r), 32'h7B27);
    step();
    wait_pair("ones_p4");
    step();
    wait_pair("ones_p5");
    check_eq("ones_p5_l", 32'(sample_l), 32'h7FFF);
    check_eq("ones_p5_r", 32'(sample_r), 32'h7FFF);
    check_eq("ones_overflow", 32'(overflow), 32'd0);
    step();

    // Constant low line
    mode = 2'd0;
    do_reset();
    wait_pair("zeros_p1");
    check_eq("zeros_p1_l", 32'(sample_l), 32'hFA26);
    check_eq("zeros_p1_r", 32'(sample_r), 32'hFA26);
    step();
    for (int p = 2; p <= 4; p++) begin
      wait_pair("zeros_px");
      step();
    end
    wait_pair("zeros_p5");
    check_eq("zeros_p5_l", 32'(sample_l), 32'h8000);
    check_eq("zeros_p5_r", 32'(sample_r), 32'h8000);
    step();

    // Channel mapping: high in left slot, low in right slot
    mode = 2'd2;
    do_reset();
    wait_pair("map_p1");
    check_eq("map_p1_l", 32'(sample_l), 32'h05D9);
    check_eq("map_p1_r", 32'(sample_r), 32'hFA26);
    step();
    for (int p = 2; p <= 4; p++) begin
      wait_pair("map_px");
      step();
    end
    wait_pair("map_p5");
    check_eq("map_p5_l", 32'(sample_l), 32'h7FFF);
    check_eq("map_p5_r", 32'(sample_r), 32'h8000);
    step();

    // Backpressure: first pair held across two further arrivals
    mode         = 2'd1;
    sample_ready = 1'b0;
    do_reset();
    wait_pair("bp_p1");
    t_rise = cyc;
    check_eq("bp_p1_l", 32'(sample_l), 32'h05D9);
    changes = 0;
    repeat (2 * 1024 + 100) begin
      step();
      if (!sample_valid || sample_l !== 16'h05D9 || sample_r !== 16'h05D9) changes++;
    end
    check_eq("bp_hold_changes", 32'(changes), 32'd0);
    check_eq("bp_overflow_set", 32'(overflow), 32'd1);
    sample_ready = 1'b1;
    hs = 0;
    repeat (500) begin
      if (sample_valid && sample_ready) hs++;
      step();
    end
    check_eq("bp_handshakes", 32'(hs), 32'd1);
    check_eq("bp_valid_after", 32'(sample_valid), 32'd0);
    check_eq("bp_overflow_sticky", 32'(overflow), 32'd1);
    wait_pair("bp_next");
    check_eq("bp_next_time", 32'(cyc - t_rise), 32'd3072);
    check_eq("bp_next_l", 32'(sample_l), 32'h7FFF);
    step();

    // Reset pulse mid-frame while a pair is pending
    sample_ready = 1'b0;
    wait_pair("pre_rst");
    repeat (300) step();
    check_eq("pre_rst_overflow", 32'(overflow), 32'd1);
    rst = 1'b1;
    step();
    check_eq("mid_rst_valid", 32'(sample_valid), 32'd0);
    check_eq("mid_rst_overflow", 32'(overflow), 32'd0);
    check_eq("mid_rst_pdm_clk", 32'(pdm_clk), 32'd0);
    rst          = 1'b0;
    cyc          = 1;
    sample_ready = 1'b1;
    wait_pair("post_rst");
    check_eq("post_rst_latency", 32'(cyc), 32'd1026);
    check_eq("post_rst_l", 32'(sample_l), 32'h05D9);
    check_eq("post_rst_r", 32'(sample_r), 32'h05D9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pdm_mic_capture.md
PDM_MIC_CAPTURE -- requirements
Module: pdm_mic_capture

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clk cycles per pdm_clk period (even, >=8; 16 gives 3.125 MHz from 50 MHz clk).
REQ-002 SHALL have parameter DECIM, default 64, meaning PDM bits per channel per output sample (power of two, 8..64).
REQ-003 SHALL have port clk, input, 1 bit: the single 50 MHz system clock; every flop is clocked by it.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port pdm_clk, output, 1 bit: microphone bit clock, driven from a flop.
REQ-006 SHALL have port pdm_data, input, 1 bit: shared stereo PDM line (left mic SEL=0, right mic SEL=1).
REQ-007 SHALL have port sample_l, output, 16 bits: signed left PCM sample.
REQ-008 SHALL have port sample_r, output, 16 bits: signed right PCM sample.
REQ-009 SHALL have port sample_valid, output, 1 bit: a stereo pair is held on sample_l/sample_r.
REQ-010 SHALL have port sample_ready, input, 1 bit: the consumer accepts the pair.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, a pair was dropped.

Function
REQ-012 SHALL keep a divider count div_cnt running 0..CLK_DIV-1 and wrapping.
REQ-013 SHALL drive pdm_clk high for div_cnt 0..CLK_DIV/2-1 and low otherwise, giving a 50 % duty cycle.
REQ-014 SHALL pass pdm_data through a 2-flop synchronizer; all sampling uses the synchronized bit.
REQ-015 SHALL sample the left bit when div_cnt==CLK_DIV/2-1 and the right bit when div_cnt==CLK_DIV-1.
REQ-016 SHALL map each bit as 1 -> +1 and 0 -> -1 into a 4th-order CIC per channel: 4 integrators updated once per sampled bit, then 4 combs with differential delay 1 evaluated once per DECIM bits.
REQ-017 SHALL hold all CIC state in 26-bit two's complement; integrator wrap-around is allowed and is exact.
REQ-018 SHALL form the output as comb result bits [25:9], saturated to the range -32768..+32767.
REQ-019 SHALL count right-channel bits; on the DECIM-th right bit it produces one stereo pair.
REQ-020 SHALL assert sample_valid exactly 2 clk cycles after the cycle in which that DECIM-th right bit is sampled.
REQ-021 SHALL hold sample_l, sample_r and sample_valid stable while sample_valid=1 and sample_ready=0.
REQ-022 SHALL complete the transfer in any cycle with valid=1 and ready=1; valid SHALL deassert the next cycle unless a new pair lands in that same cycle.
REQ-023 SHALL handle a new pair arriving while a pair is pending and not accepted as follows: keep the old pair, discard the new pair, set overflow to 1.
REQ-024 SHALL treat a new pair arriving in the same cycle as a handshake as accepted; no overflow is flagged.
REQ-025 SHALL keep the CIC running regardless of backpressure; PDM sampling never stalls.

Reset
REQ-026 SHALL, while rst=1, force div_cnt, the synchronizer, all integrators, comb delays, the bit counter and overflow to 0.
REQ-027 SHALL, while rst=1, force pdm_clk=0, sample_valid=0 and sample_l=sample_r=0.
REQ-028 SHALL make pdm_clk rise on the first cycle after rst falls, and on reset mid-frame discard the partial frame with no pair emitted.

Structure
REQ-029 SHALL place CIC_ORDER=4, ACC_W=26, OUT_W=16 and the output bit slice/saturation constants in shared package mic_pkg.
REQ-030 SHALL implement one channel (integrators, combs, saturation) as sub-module cic_decimator, instantiated twice (left and right); divider, sampling, handshake and overflow stay in pdm_mic_capture.

Verification
REQ-031 SHALL cover constant pdm_data=1 -> from the 5th pair on, sample_l=sample_r=0x7FFF (saturated), overflow=0 with ready tied high.
REQ-032 SHALL cover constant pdm_data=0 -> from the 5th pair on, both samples are 0x8000.
REQ-033 SHALL cover a line driven 1 during the left slot and 0 during the right slot -> sample_l=0x7FFF and sample_r=0x8000 after settling, proving channel mapping.
REQ-034 SHALL cover a pair period of CLK_DIV*DECIM=1024 clk cycles with default parameters; valid appears 2 cycles after the 64th right sample, checked by cycle counter.
REQ-035 SHALL cover ready held low for 2 pair periods -> first pair held unchanged, overflow=1, second pair never seen; a later ready=1 transfers exactly one pair.
REQ-036 SHALL cover rst pulsed 1 cycle mid-frame -> next cycle valid=0, overflow=0, pdm_clk=0; the next pair arrives 1024+2 cycles after rst release.
